data_ram: RTL and testbench

Synchronous-write data memory with configurable wait states. Sits directly downstream of the memory-access stage. It consumes that stage's chip-enable, write-enable, address, byte-select and store data, and returns load data on the same bus. While an access is still in its wait states it raises a stall request to pipeline control, which holds the memory-access stage inputs stable.

---
 rtl/data_ram_pkg.sv | 40 ++++
 rtl/data_ram_bank.sv | 24 ++
 rtl/data_ram.sv | 113 +++++++++++
 tb/tb_data_ram.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared constants, FSM encoding and request bundle for the data_ram slice.
// Alignment checking helper is used when DATA_RAM_ALIGN_CHK_EN is defined.
package data_ram_pkg;

    localparam int RegBus      = 32;
    localparam int DataAddrBus = 32;
    localparam int NUM_LANES   = 4;
    localparam int LANE_W      = 8;

    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic RstnEnable  = 1'b0;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'b00,
        DRAM_WAIT = 2'b01,
        DRAM_DONE = 2'b10
    } dram_state_e;

    typedef struct packed {
        logic                       ce;
        logic                       we;
        logic [DataAddrBus-1:0]     addr;
        logic [NUM_LANES-1:0]       sel;
        logic [RegBus-1:0]          data;
    } dram_req_t;

    // Full-word access must be word aligned; halfword access must be even.
    function automatic logic is_misaligned(input logic [NUM_LANES-1:0] sel,
                                           input logic [1:0]           lo);
        logic bad;
        bad = 1'b0;
        if (sel == 4'b1111 && lo != 2'b00)
            bad = 1'b1;
        if ((sel == 4'b1100 || sel == 4'b0011) && lo[0])
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// One byte lane of the data memory: asynchronous read, synchronous write.
module data_ram_bank
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_ram.sv
// Byte-lane data memory with WAIT_CYCLES wait states and a pipeline stall request.
// Define DATA_RAM_ALIGN_CHK_EN to flag and suppress misaligned accesses.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   we,
    input  logic [DataAddrBus-1:0] addr,
    input  logic [NUM_LANES-1:0]   sel,
    input  logic [RegBus-1:0]      data_i,
    output logic [RegBus-1:0]      data_o,
    output logic                   stall_req,
    output logic                   ack,
    output logic                   addr_err
);

    dram_req_t   req;
    dram_state_e state, state_n;
    logic [2:0]  wcnt, wcnt_n;
    logic        run;
    logic        completion;
    logic        misaligned;
    logic        commit;
    logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes;
    logic        unused_addr;

    assign req = '{ce: ce, we: we, addr: addr, sel: sel, data: data_i};
    assign run = (rst != RstnEnable);
    assign unused_addr = ^{req.addr[DataAddrBus-1:ADDR_W+2], req.addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DRAM_IDLE;
            wcnt  <= 3'd0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // The request cycle in IDLE is the first wait state, so the counter
    // covers the remaining WAIT_CYCLES-1 stall cycles before DONE.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        unique case (state)
            DRAM_IDLE: begin
                if (req.ce == ChipEnable && WAIT_CYCLES > 0) begin
                    if (WAIT_CYCLES == 1) begin
                        state_n = DRAM_DONE;
                    end else begin
                        state_n = DRAM_WAIT;
                        wcnt_n  = 3'(WAIT_CYCLES - 2);
                    end
                end
            end
            DRAM_WAIT: begin
                if (req.ce != ChipEnable) begin
                    state_n = DRAM_IDLE;
                    wcnt_n  = 3'd0;
                end else if (wcnt == 3'd0) begin
                    state_n = DRAM_DONE;
                end else begin
                    wcnt_n = wcnt - 3'd1;
                end
            end
            DRAM_DONE: begin
                state_n = DRAM_IDLE;
            end
            default: begin
                state_n = DRAM_IDLE;
                wcnt_n  = 3'd0;
            end
        endcase
    end

`ifdef DATA_RAM_ALIGN_CHK_EN
    assign misaligned = is_misaligned(req.sel, req.addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Gating with run keeps the zero-wait completion quiet while in reset.
    assign completion = run &
                        ((state == DRAM_DONE) |
                         ((state == DRAM_IDLE) & (req.ce == ChipEnable) & (WAIT_CYCLES == 0)));

    assign ack       = completion;
    assign stall_req = run & (req.ce == ChipEnable) & ~completion;
    assign addr_err  = completion & misaligned;
    assign commit    = completion & (req.ce == ChipEnable) & (req.we == WriteEnable) & ~misaligned;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        data_ram_bank #(
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .wr_en (commit & req.sel[i]),
            .idx   (req.addr[ADDR_W+1:2]),
            .wdata (req.data[i*LANE_W +: LANE_W]),
            .rdata (rd_lanes[i])
        );
    end

    assign data_o = ((req.ce == ChipEnable) && (req.we != WriteEnable) && !misaligned)
                    ? rd_lanes : '0;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench: one WAIT_CYCLES=0 and one WAIT_CYCLES=2 instance against a byte-array model.
module tb_data_ram;
    import data_ram_pkg::*;

`ifdef DATA_RAM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0]        ce, we, stall, ack, aerr;
    logic [1:0][31:0]  addr, din, dout;
    logic [1:0][3:0]   sel;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mb [2][128];

    always #5 clk = ~clk;

    data_ram #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
        .data_i(din[0]), .data_o(dout[0]), .stall_req(stall[0]), .ack(ack[0]), .addr_err(aerr[0]));

    data_ram #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
        .data_i(din[1]), .data_o(dout[1]), .stall_req(stall[1]), .ack(ack[1]), .addr_err(aerr[1]));

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit misal(input logic [3:0] s, input logic [31:0] a);
        return (s == 4'hF && a[1:0] != 2'b00) || ((s == 4'hC || s == 4'h3) && a[0]);
    endfunction

    // Memory model is byte addressed: byte offset k of a word is data[31-8k -: 8].
    function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
        int b;
        b = int'({a[6:2], 2'b00});
        return {mb[d][b], mb[d][b+1], mb[d][b+2], mb[d][b+3]};
    endfunction

    task automatic model_wr(input int d, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] v);
        int b;
        b = int'({a[6:2], 2'b00});
        for (int k = 0; k < 4; k++)
            if (s[3-k]) mb[d][b+k] = v[31-8*k -: 8];
    endtask

    task automatic run_acc(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] v, output logic [31:0] rd, output int lat,
                           output int stalls, output logic err);
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = v;
        lat = 0; stalls = 0; rd = '0; err = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (stall[d]) stalls++;
            if (ack[d]) begin
                lat = c; rd = dout[d]; err = aerr[d];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ce[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic access_chk(input int d, input bit w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] v);
        logic [31:0] rd, exp_rd;
        int lat, stalls;
        logic err;
        bit bad;
        bad = ALIGN && misal(s, a);
        exp_rd = bad ? 32'h0 : model_rd(d, a);
        run_acc(d, w, a, s, v, rd, lat, stalls, err);
        chk($sformatf("latency d%0d", d), 32'(lat), 32'(wc(d) + 1));
        chk($sformatf("stall_cycles d%0d", d), 32'(stalls), 32'(wc(d)));
        chk($sformatf("addr_err d%0d a=%08h s=%h", d, a, s), 32'(err), 32'(bad));
        if (!w)
            chk($sformatf("load d%0d a=%08h", d, a), rd, exp_rd);
        else if (!bad)
            model_wr(d, a, s, v);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] v;
        int          lat;
        int          stalls;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl[4];
        logic [31:0] rd, old;
        int          lat, stalls;
        logic        err;
        logic [3:0]  sels[9];

        tbl[0] = '{1'b1, 32'h10, 4'hF, 32'h11223344, 3, 2, 32'h0};
        tbl[1] = '{1'b0, 32'h10, 4'hF, 32'h0,        3, 2, 32'h11223344};
        tbl[2] = '{1'b1, 32'h11, 4'h4, 32'hAAAAAAAA, 3, 2, 32'h0};
        tbl[3] = '{1'b0, 32'h10, 4'hF, 32'h0,        3, 2, 32'h11AA3344};
        sels = '{4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h6};

        // Reset state, with the zero-wait instance requesting a store.
        rst = 1'b0;
        ce = '0; we = '0; addr = '0; sel = '0; din = '0;
        ce[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
        #12;
        chk("rst ack w0", 32'(ack[0]), 32'h0);
        chk("rst stall w0", 32'(stall[0]), 32'h0);
        chk("rst data_o w0", dout[0], 32'h0);
        chk("rst stall w2", 32'(stall[1]), 32'h0);
        chk("rst ack w2", 32'(ack[1]), 32'h0);
        chk("rst addr_err w2", 32'(aerr[1]), 32'h0);
        chk("rst data_o w2", dout[1], 32'h0);
        chk("rst state w2", 32'(u_w2.state), 32'(DRAM_IDLE));
        ce[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Give every modelled word a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++)
                access_chk(d, 1'b1, 32'(i * 4), 4'hF, $urandom);

        // Directed table on the two-wait-state instance.
        for (int i = 0; i < 4; i++) begin
            run_acc(1, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].v, rd, lat, stalls, err);
            chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d stalls", i), 32'(stalls), 32'(tbl[i].stalls));
            if (tbl[i].w) model_wr(1, tbl[i].a, tbl[i].s, tbl[i].v);
            else          chk($sformatf("tbl%0d data", i), rd, tbl[i].exp);
        end

        // Flush: ce dropped in the first WAIT cycle.
        old = model_rd(1, 32'h20);
        ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; sel[1] = 4'hF; din[1] = 32'hDEADBEEF;
        @(negedge clk);
        chk("flush req stall", 32'(stall[1]), 32'h1);
        chk("flush req ack", 32'(ack[1]), 32'h0);
        @(posedge clk); #1;
        ce[1] = 1'b0;
        @(negedge clk);
        chk("flush ack", 32'(ack[1]), 32'h0);
        chk("flush stall", 32'(stall[1]), 32'h0);
        @(posedge clk); #1;
        chk("flush state", 32'(u_w2.state), 32'(DRAM_IDLE));
        we[1] = 1'b0;
        run_acc(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat, stalls, err);
        chk("flush word kept", rd, old);

        // Reset in the middle of a wait.
        old = model_rd(1, 32'h30);
        ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; sel[1] = 4'hF; din[1] = 32'h12345678;
        @(posedge clk); #1;
        chk("pre-rst stall", 32'(stall[1]), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid-rst stall", 32'(stall[1]), 32'h0);
        chk("mid-rst ack", 32'(ack[1]), 32'h0);
        chk("mid-rst state", 32'(u_w2.state), 32'(DRAM_IDLE));
        chk("mid-rst wcnt", 32'(u_w2.wcnt), 32'h0);
        chk("mid-rst data_o", dout[1], 32'h0);
        @(posedge clk); #1;
        ce[1] = 1'b0; we[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        run_acc(1, 1'b0, 32'h30, 4'hF, 32'h0, rd, lat, stalls, err);
        chk("rst word kept", rd, old);

        // Zero wait states: store then load back to back.
        run_acc(0, 1'b1, 32'h40, 4'hF, 32'h1, rd, lat, stalls, err);
        chk("w0 store latency", 32'(lat), 32'h1);
        chk("w0 store stalls", 32'(stalls), 32'h0);
        model_wr(0, 32'h40, 4'hF, 32'h1);
        run_acc(0, 1'b0, 32'h40, 4'hF, 32'h0, rd, lat, stalls, err);
        chk("w0 load latency", 32'(lat), 32'h1);
        chk("w0 load stalls", 32'(stalls), 32'h0);
        chk("w0 load data", rd, 32'h1);

        // Misaligned full-word store.
        old = model_rd(1, 32'h40);
        run_acc(1, 1'b1, 32'h42, 4'hF, 32'hCAFEF00D, rd, lat, stalls, err);
        chk("misaligned addr_err", 32'(err), 32'(ALIGN));
        if (!ALIGN) model_wr(1, 32'h40, 4'hF, 32'hCAFEF00D);
        run_acc(1, 1'b0, 32'h40, 4'hF, 32'h0, rd, lat, stalls, err);
        chk("misaligned word", rd, ALIGN ? old : 32'hCAFEF00D);

        // Random traffic against the model; upper address bits are noise.
        for (int i = 0; i < 200; i++) begin
            int d;
            d = int'($urandom_range(1, 0));
            access_chk(d, 1'($urandom), $urandom & 32'hFFFF_F07F,
                       sels[$urandom_range(8, 0)], $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
